// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 32-bit shifter
// (sll / sra) with a single registered result slot and one-result-per-cycle throughput.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | result register holds nothing, resp_valid=0
// ST_FULL  | result register holds a result, resp_valid=1
module shift_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_operand,
  input  logic [4:0]  req0_shiftamt,
  input  logic        req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_operand,
  input  logic [4:0]  req1_shiftamt,
  input  logic        req1_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               resp_id_q, resp_id_d;
  logic [31:0]        resp_data_q, resp_data_d;

  logic               slot_free;
  logic               winner;
  logic               grant;
  logic [31:0]        sel_operand;
  logic [4:0]         sel_amt;
  logic               sel_op;
  logic signed [31:0] sra_res;
  logic [31:0]        shift_res;

  assign slot_free = (state_q == ST_EMPTY) || resp_ready;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && req1_valid) winner = ~last_grant_q;
    else if (req1_valid)          winner = 1'b1;
  end

  // reset_n gates the readys so nothing can look accepted while reset is held.
  assign grant      = (req0_valid || req1_valid) && slot_free && reset_n;
  assign req0_ready = grant && !winner;
  assign req1_ready = grant && winner;

  assign sel_operand = winner ? req1_operand  : req0_operand;
  assign sel_amt     = winner ? req1_shiftamt : req0_shiftamt;
  assign sel_op      = winner ? req1_op       : req0_op;

  assign sra_res   = $signed(sel_operand) >>> sel_amt;
  assign shift_res = sel_op ? sra_res : (sel_operand << sel_amt);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    if (grant) begin
      state_d      = ST_FULL;
      last_grant_d = winner;
      resp_id_d    = winner;
      resp_data_d  = shift_res;
    end else if (state_q == ST_FULL && resp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= 1'b1;
      resp_id_q    <= 1'b0;
      resp_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, single request, contention,
// boundary shift amounts, backpressure and asynchronous mid-operation reset.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_op;
  logic [31:0] req0_operand;
  logic [4:0]  req0_shiftamt;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req1_operand;
  logic [4:0]  req1_shiftamt;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  int n_cmp = 0;
  int n_bad = 0;

  shift_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_operand (req0_operand),
    .req0_shiftamt(req0_shiftamt),
    .req0_op      (req0_op),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_operand (req1_operand),
    .req1_shiftamt(req1_shiftamt),
    .req1_op      (req1_op),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Command fields of a stalled requester must not change until accepted.
  logic        pend0 = 1'b0, pend1 = 1'b0;
  logic [37:0] hold0, hold1;
  always @(negedge clock) begin
    if (pend0 && req0_valid) chk("hold0", {26'h0, req0_op, req0_shiftamt}, {26'h0, hold0[37:32]});
    if (pend0 && req0_valid) chk("hold0_opnd", req0_operand, hold0[31:0]);
    if (pend1 && req1_valid) chk("hold1", {26'h0, req1_op, req1_shiftamt}, {26'h0, hold1[37:32]});
    if (pend1 && req1_valid) chk("hold1_opnd", req1_operand, hold1[31:0]);
    pend0 = reset_n && req0_valid && !req0_ready;
    pend1 = reset_n && req1_valid && !req1_ready;
    hold0 = {req0_op, req0_shiftamt, req0_operand};
    hold1 = {req1_op, req1_shiftamt, req1_operand};
  end

  typedef struct {
    logic        op;
    logic [31:0] opnd;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  vec_t bvec [5];

  initial begin
    bvec[0] = '{1'b0, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF};
    bvec[1] = '{1'b0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    bvec[2] = '{1'b1, 32'h4000_0000, 5'd30, 32'h0000_0001};
    bvec[3] = '{1'b1, 32'h8000_0000, 5'd0,  32'h8000_0000};
    bvec[4] = '{1'b0, 32'h1234_5678, 5'd8,  32'h3456_7800};

    reset_n = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b0; req0_operand = 32'h0; req0_shiftamt = 5'd0;
    req1_valid = 1'b1; req1_op = 1'b0; req1_operand = 32'h0; req1_shiftamt = 5'd0;
    resp_ready = 1'b1;
    tick(); tick();
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_data",  resp_data, 32'h0);
    chk("rst_resp_id",    {31'h0, resp_id}, 32'h0);
    chk("rst_req0_ready", {31'h0, req0_ready}, 32'h0);
    chk("rst_req1_ready", {31'h0, req1_ready}, 32'h0);

    // Contention: 0,1,0,1 back to back, starting right after reset release.
    req0_op = 1'b0; req0_operand = 32'h0000_0001; req0_shiftamt = 5'd4;
    req1_op = 1'b1; req1_operand = 32'h7FFF_FFF0; req1_shiftamt = 5'd4;
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("cont_req0_ready", {31'h0, req0_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_req1_ready", {31'h0, req1_ready}, (i % 2 == 0) ? 32'h0 : 32'h1);
      tick();
      chk("cont_valid", {31'h0, resp_valid}, 32'h1);
      chk("cont_id",    {31'h0, resp_id}, (i % 2 == 0) ? 32'h0 : 32'h1);
      chk("cont_data",  resp_data, (i % 2 == 0) ? 32'h0000_0010 : 32'h07FF_FFFF);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("drain_valid", {31'h0, resp_valid}, 32'h0);

    // Single request on requester 0.
    req0_valid = 1'b1; req0_op = 1'b1; req0_operand = 32'h8000_0000; req0_shiftamt = 5'd31;
    #1;
    chk("single_ready0", {31'h0, req0_ready}, 32'h1);
    chk("single_ready1", {31'h0, req1_ready}, 32'h0);
    tick();
    req0_valid = 1'b0;
    chk("single_valid", {31'h0, resp_valid}, 32'h1);
    chk("single_data",  resp_data, 32'hFFFF_FFFF);
    chk("single_id",    {31'h0, resp_id}, 32'h0);
    tick();
    chk("single_drain", {31'h0, resp_valid}, 32'h0);

    // Boundary shift amounts through requester 1 alone, one per cycle.
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req1_op = bvec[i].op; req1_operand = bvec[i].opnd; req1_shiftamt = bvec[i].amt;
      tick();
      chk("bnd_data", resp_data, bvec[i].exp);
      chk("bnd_id",   {31'h0, resp_id}, 32'h1);
    end
    req1_valid = 1'b0;
    tick();

    // Backpressure with both requesters valid; last grant was 1, so 0 goes first.
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b0; req0_operand = 32'h0000_0003; req0_shiftamt = 5'd1;
    req1_valid = 1'b1; req1_op = 1'b1; req1_operand = 32'h8000_0000; req1_shiftamt = 5'd4;
    #1;
    chk("bp_first_ready0", {31'h0, req0_ready}, 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready0", {31'h0, req0_ready}, 32'h0);
      chk("bp_ready1", {31'h0, req1_ready}, 32'h0);
      chk("bp_data",   resp_data, 32'h0000_0006);
      chk("bp_id",     {31'h0, resp_id}, 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_release_ready1", {31'h0, req1_ready}, 32'h1);
    chk("bp_release_ready0", {31'h0, req0_ready}, 32'h0);
    tick();
    chk("bp_next_data", resp_data, 32'hF800_0000);
    chk("bp_next_id",   {31'h0, resp_id}, 32'h1);

    // Asynchronous reset while FULL and stalled.
    resp_ready = 1'b0;
    #2;
    chk("mid_full", {31'h0, resp_valid}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'h0, resp_valid}, 32'h0);
    chk("mid_rst_data",  resp_data, 32'h0);
    chk("mid_rst_ready0", {31'h0, req0_ready}, 32'h0);
    tick();
    #2;
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready0", {31'h0, req0_ready}, 32'h1);
    chk("post_rst_ready1", {31'h0, req1_ready}, 32'h0);
    tick();
    chk("post_rst_valid", {31'h0, resp_valid}, 32'h1);
    chk("post_rst_id",    {31'h0, resp_id}, 32'h0);
    chk("post_rst_data",  resp_data, 32'h0000_0006);

    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 and the shift amount at 5 bits.
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 presents a shift command.
REQ-005 req0_ready  output  1  requester 0 command accepted this cycle when high together with req0_valid.
REQ-006 req0_operand  input  32  requester 0 data operand.
REQ-007 req0_shiftamt  input  5  requester 0 shift amount, 0-31.
REQ-008 req0_op  input  1  requester 0 operation: 0 = logical left shift, 1 = arithmetic right shift.
REQ-009 req1_valid, req1_ready, req1_operand, req1_shiftamt, req1_op SHALL exist with the same directions, widths and meanings for requester 1.
REQ-010 resp_valid  output  1  result register holds a valid result.
REQ-011 resp_ready  input  1  consumer accepts the result this cycle.
REQ-012 resp_id  output  1  index of the requester that issued the result.
REQ-013 resp_data  output  32  shifted result.

Function
REQ-014 The block SHALL contain exactly one shared 32-bit shifter datapath supporting both ops; it SHALL NOT instantiate one shifter per requester.
REQ-015 The FSM SHALL have two states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-016 Slot free = (state==EMPTY) or (state==FULL and resp_ready==1).
REQ-017 The grant SHALL be round-robin. If only one requester is valid, it wins. If both are valid, the requester not equal to last_grant wins.
REQ-018 reqN_ready SHALL be high only when the slot is free and requester N is the winner; at most one ready SHALL be high per cycle.
REQ-019 reqN_ready SHALL be low whenever the slot is not free, regardless of valid.
REQ-020 On acceptance (valid & ready) at edge N, resp_data, resp_id and resp_valid=1 SHALL be registered at that edge: latency is exactly 1 cycle.
REQ-021 last_grant SHALL update to the accepted requester's index only on acceptance.
REQ-022 FULL with resp_ready=1 and a new acceptance in the same cycle: the new result SHALL replace the old one with no bubble, allowing one result per cycle.
REQ-023 FULL with resp_ready=1 and no acceptance: the FSM SHALL go to EMPTY.
REQ-024 FULL with resp_ready=0: resp_data and resp_id SHALL hold stable and no request SHALL be accepted.
REQ-025 Arithmetic right shift SHALL fill vacated bits with operand[31]; left shift SHALL fill with 0.
REQ-026 Shift amount 0 SHALL return the operand unchanged.
REQ-027 A requester held off by ready=0 SHALL be served no later than after one acceptance of the other requester (no starvation).
REQ-028 Requesters SHALL hold the command fields stable while valid=1 and ready=0; the bench SHALL flag any violation.

Reset
REQ-029 While reset_n=0, outputs SHALL be: resp_valid=0, resp_data=0, resp_id=0, req0_ready=0, req1_ready=0.
REQ-030 Reset SHALL set state=EMPTY and last_grant=1, so requester 0 wins the first contended grant.
REQ-031 Reset asserted mid-operation SHALL discard the held result immediately, without waiting for a clock edge.
REQ-032 The first acceptance SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-033 Single request: req0 sra, operand 0x80000000, amt 31, resp_ready=1 -> next cycle resp_valid=1, resp_data=0xFFFFFFFF, resp_id=0.
REQ-034 Contention: both valid every cycle, resp_ready=1 -> accepts alternate 0,1,0,1 with one result per cycle. Operands are req0 sll 0x00000001 amt 4 and req1 sra 0x7FFFFFF0 amt 4. Results alternate 0x00000010 and 0x07FFFFFF.
REQ-035 Backpressure: result held with resp_ready=0 for 3 cycles while both requesters are valid -> both readys stay 0 and resp_data stays stable. When resp_ready rises, the next grant is issued in the same cycle.
REQ-036 Boundary amounts: sll 0xFFFFFFFF amt 0 -> 0xFFFFFFFF; sll 0xFFFFFFFF amt 31 -> 0x80000000; sra 0x40000000 amt 30 -> 0x00000001.
REQ-037 Reset mid-operation: reset_n pulled low while FULL -> resp_valid=0 with no clock edge. After release, with both requesters valid, req0 is granted first.
